ps_stck_loop_ctl: RTL
=====================

Name: ps_stck_loop_ctl

Overview:
- Parametrised program-sequencer control-flow unit: PC stack plus nested hardware-loop stack (loop end address and current count per level).
- Sits beside the fetch-address register in the sequencer.
- Each cycle it compares the fetch address against the innermost loop end. It issues a same-cycle redirect to the loop start and handles call/return/push/pop on the PC stack.
- Generalises the 2-entry PC stack and single loop counter to configurable depths and nesting, with underflow/collision detection.

Parameters:
AW, 16, address/data width of stack entries
PC_DEPTH, 8, PC stack entries (>=2)
LP_DEPTH, 4, loop nesting levels (>=1, <=PC_DEPTH)
CW, 16, loop count width

Ports:
clk  in  1  single clock, all state on posedge
rst  in  1  synchronous active-low reset
ps_faddr  in  AW  current fetch address
ps_fvld  in  1  fetch address valid this cycle (0 while stalled)
ps_call  in  1  push ps_call_ret onto PC stack
ps_call_ret  in  AW  return address for call
ps_rtrn  in  1  pop PC stack, redirect to popped value
ps_psh  in  1  push ps_psh_dt (explicit PCSTK push)
ps_psh_dt  in  AW  push data
ps_pop  in  1  pop PC stack, no redirect
ps_loop  in  1  start loop
ps_loop_strt  in  AW  loop body first address
ps_loop_end  in  AW  loop body last address
ps_loop_cnt  in  CW  iteration count
ps_stcky_clr  in  1  clear sticky error bits
ps_redir  out  1  redirect fetch next cycle
ps_redir_addr  out  AW  redirect target
ps_pcstck  out  AW  PC stack top (0 when empty)
ps_pcstck_pntr  out  $clog2(PC_DEPTH+1)  PC stack occupancy
ps_laddr  out  AW  innermost loop end (0 if none)
ps_curlcntr  out  CW  innermost loop count (0 if none)
ps_lp_pntr  out  $clog2(LP_DEPTH+1)  loop nesting depth
ps_stcky  out  6  status, bits below
ps_halt  out  1  = ps_stcky[2] | ps_stcky[4]

Behaviour:
- Reset (rst=0 at posedge): both stacks empty, all pointers 0, stack arrays cleared. ps_stcky=6'b000001; all other outputs 0.
- ps_stcky bits:
  - [0] PC empty (live)
  - [1] PC full (live)
  - [2] PC overflow (sticky)
  - [3] PC underflow (sticky)
  - [4] loop-stack overflow (sticky)
  - [5] collision (sticky)
- Sticky bits clear only on reset or ps_stcky_clr. If a set event occurs in the same cycle as ps_stcky_clr, the set wins.
- Loop-end hit (lend): ps_fvld & ps_lp_pntr!=0 & ps_faddr==ps_laddr.
  - If ps_curlcntr>1: ps_redir=1, ps_redir_addr=PC stack top (loop start); count decrements next edge.
  - If ps_curlcntr==1: no redirect. Next edge pops the loop stack and the PC stack; the outer loop becomes innermost.
- ps_rtrn: ps_redir=1, ps_redir_addr=ps_pcstck (combinational, same cycle); pop at next edge.
- Loop start: pushes ps_loop_strt on the PC stack and {ps_loop_end, ps_loop_cnt} on the loop stack at the same edge. ps_loop_cnt==0 is loaded as 1 (body executes once).
- One PC-stack operation per cycle, priority:
  1. lend termination pop
  2. ps_rtrn
  3. ps_pop
  4. ps_loop
  5. ps_call
  6. ps_psh
  - Every additional asserted request is dropped and sets [5].
  - lend with count>1 is not a stack op and does not collide.
  - ps_redir from lend beats ps_redir from ps_rtrn; ps_rtrn is then dropped and [5] set.
- Full/empty handling:
  - Push when PC pointer==PC_DEPTH: no state change, [2] set.
  - Pop or return when empty: no change, [3] set, no redirect; ps_redir_addr=0.
  - ps_loop when loop pointer==LP_DEPTH or PC full: neither stack changes, [4] or [2] set accordingly.
- While ps_halt=1 all push/call/loop requests are ignored (no further sticky updates except collision). Pops and returns remain legal.
- Stall: ps_fvld=0 suppresses lend evaluation; counts hold.
- Outputs:
  - ps_pcstck, ps_laddr, ps_curlcntr, pointers and stcky[1:0] are registered views of state, updated the edge after the operation.
  - ps_redir and ps_redir_addr are combinational from registered state plus inputs.
- Arithmetic: the count decrement never wraps below 1. Pointers are saturating, unsigned.

Test Plan:
1. Reset then ps_psh with ps_psh_dt=0x0010..0x0017 (8 cycles) -> pntr=8, stcky=6'b000010, ps_pcstck=0x0017. A 9th push -> pntr stays 8, stcky[2]=1, ps_halt=1.
2. Empty stack, ps_rtrn -> ps_redir=0, stcky[3]=1. Then ps_stcky_clr -> stcky=6'b000001.
3. ps_loop strt=0x0020, end=0x0023, cnt=3; fetch 0x20..0x23 repeatedly:
   - redirect to 0x0020 at the 1st and 2nd hit, none at the 3rd hit.
   - after the 3rd hit: lp_pntr=0, pcstck_pntr=0.
4. Nested loops: outer (0x30, 0x40, 2), inner (0x32, 0x34, 2):
   - inner redirects once, terminates, then outer ps_laddr=0x0040, curlcntr=2.
   - total fetches of 0x34 = 4.
5. ps_call ret=0x0055 and ps_psh in the same cycle -> only 0x0055 pushed, stcky[5]=1. ps_rtrn -> ps_redir_addr=0x0055.
6. Loop cnt=0 strt=end=0x0060 -> one fetch, no redirect, stacks empty. ps_fvld=0 held at 0x0060 with cnt=2 -> curlcntr holds 2.

Source files
------------

// File: rtl/ps_stck_loop_ctl.sv
// Program-sequencer control flow: PC stack plus nested hardware-loop stack.
// Redirects fetch on loop-end hits and returns; arbitrates one PC-stack op per cycle.
module ps_stck_loop_ctl #(
  parameter int AW       = 16,
  parameter int PC_DEPTH = 8,
  parameter int LP_DEPTH = 4,
  parameter int CW       = 16,
  localparam int PW      = $clog2(PC_DEPTH + 1),
  localparam int LW      = $clog2(LP_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ps_faddr,
  input  logic          ps_fvld,
  input  logic          ps_call,
  input  logic [AW-1:0] ps_call_ret,
  input  logic          ps_rtrn,
  input  logic          ps_psh,
  input  logic [AW-1:0] ps_psh_dt,
  input  logic          ps_pop,
  input  logic          ps_loop,
  input  logic [AW-1:0] ps_loop_strt,
  input  logic [AW-1:0] ps_loop_end,
  input  logic [CW-1:0] ps_loop_cnt,
  input  logic          ps_stcky_clr,
  output logic          ps_redir,
  output logic [AW-1:0] ps_redir_addr,
  output logic [AW-1:0] ps_pcstck,
  output logic [PW-1:0] ps_pcstck_pntr,
  output logic [AW-1:0] ps_laddr,
  output logic [CW-1:0] ps_curlcntr,
  output logic [LW-1:0] ps_lp_pntr,
  output logic [5:0]    ps_stcky,
  output logic          ps_halt
);

  localparam int PIW = (PC_DEPTH > 1) ? $clog2(PC_DEPTH) : 1;
  localparam int LIW = (LP_DEPTH > 1) ? $clog2(LP_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NONE, OP_TERM, OP_RTRN, OP_POP, OP_LOOP, OP_CALL, OP_PSH
  } op_e;

  logic [AW-1:0] pc_stk_q [PC_DEPTH];
  logic [AW-1:0] pc_stk_d [PC_DEPTH];
  logic [PW-1:0] pc_ptr_q, pc_ptr_d;
  logic [AW-1:0] lp_end_q [LP_DEPTH];
  logic [AW-1:0] lp_end_d [LP_DEPTH];
  logic [CW-1:0] lp_cnt_q [LP_DEPTH];
  logic [CW-1:0] lp_cnt_d [LP_DEPTH];
  logic [LW-1:0] lp_ptr_q, lp_ptr_d;
  logic [5:2]    stcky_q, stcky_d;

  logic           pc_empty, pc_full, lp_empty, lp_full, halt;
  logic [PIW-1:0] pc_top_idx, pc_push_idx;
  logic [LIW-1:0] lp_top_idx, lp_push_idx;
  logic [AW-1:0]  pc_top, lp_end_top, push_data;
  logic [CW-1:0]  lp_cnt_top;
  logic           lend, lend_rpt, lend_term, rtrn_req, collision;
  logic [5:0]     req;
  logic           set_ovf, set_unf, set_lovf;
  op_e            op;

  assign pc_empty    = (pc_ptr_q == '0);
  assign pc_full     = (pc_ptr_q == PW'(PC_DEPTH));
  assign lp_empty    = (lp_ptr_q == '0);
  assign lp_full     = (lp_ptr_q == LW'(LP_DEPTH));
  assign halt        = stcky_q[2] | stcky_q[4];
  assign pc_top_idx  = PIW'(pc_ptr_q - 1'b1);
  assign pc_push_idx = PIW'(pc_ptr_q);
  assign lp_top_idx  = LIW'(lp_ptr_q - 1'b1);
  assign lp_push_idx = LIW'(lp_ptr_q);
  assign pc_top      = pc_empty ? '0 : pc_stk_q[pc_top_idx];
  assign lp_end_top  = lp_empty ? '0 : lp_end_q[lp_top_idx];
  assign lp_cnt_top  = lp_empty ? '0 : lp_cnt_q[lp_top_idx];

  // A repeating loop end is not a stack op, but it still owns the redirect,
  // so a return in the same cycle is dropped as a collision.
  assign lend      = ps_fvld & ~lp_empty & (ps_faddr == lp_end_top);
  assign lend_rpt  = lend & (lp_cnt_top > CW'(1));
  assign lend_term = lend & ~lend_rpt;
  assign rtrn_req  = ps_rtrn & ~lend;

  assign req       = {ps_psh, ps_call, ps_loop, ps_pop, rtrn_req, lend_term};
  assign collision = (|(req & (req - 6'd1))) | (ps_rtrn & lend);
  assign push_data = (op == OP_CALL) ? ps_call_ret : ps_psh_dt;

  always_comb begin
    op = OP_NONE;
    if (lend_term)    op = OP_TERM;
    else if (rtrn_req) op = OP_RTRN;
    else if (ps_pop)  op = OP_POP;
    else if (ps_loop) op = OP_LOOP;
    else if (ps_call) op = OP_CALL;
    else if (ps_psh)  op = OP_PSH;
  end

  always_comb begin
    pc_stk_d = pc_stk_q;
    pc_ptr_d = pc_ptr_q;
    lp_end_d = lp_end_q;
    lp_cnt_d = lp_cnt_q;
    lp_ptr_d = lp_ptr_q;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    set_lovf = 1'b0;
    if (lend_rpt) lp_cnt_d[lp_top_idx] = lp_cnt_top - 1'b1;
    case (op)
      OP_TERM, OP_RTRN, OP_POP: begin
        if (op == OP_TERM) lp_ptr_d = lp_ptr_q - 1'b1;
        if (pc_empty) set_unf = 1'b1;
        else          pc_ptr_d = pc_ptr_q - 1'b1;
      end
      OP_LOOP: begin
        if (!halt) begin
          set_lovf = lp_full;
          set_ovf  = pc_full;
          if (!lp_full && !pc_full) begin
            pc_stk_d[pc_push_idx] = ps_loop_strt;
            pc_ptr_d              = pc_ptr_q + 1'b1;
            lp_end_d[lp_push_idx] = ps_loop_end;
            lp_cnt_d[lp_push_idx] = (ps_loop_cnt == '0) ? CW'(1) : ps_loop_cnt;
            lp_ptr_d              = lp_ptr_q + 1'b1;
          end
        end
      end
      OP_CALL, OP_PSH: begin
        if (!halt) begin
          if (pc_full) begin
            set_ovf = 1'b1;
          end else begin
            pc_stk_d[pc_push_idx] = push_data;
            pc_ptr_d              = pc_ptr_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Set events win over a simultaneous clear.
  assign stcky_d = (ps_stcky_clr ? 4'b0000 : stcky_q) | {collision, set_lovf, set_unf, set_ovf};

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PC_DEPTH; i++) pc_stk_q[i] <= '0;
      for (int i = 0; i < LP_DEPTH; i++) begin
        lp_end_q[i] <= '0;
        lp_cnt_q[i] <= '0;
      end
      pc_ptr_q <= '0;
      lp_ptr_q <= '0;
      stcky_q  <= '0;
    end else begin
      pc_stk_q <= pc_stk_d;
      lp_end_q <= lp_end_d;
      lp_cnt_q <= lp_cnt_d;
      pc_ptr_q <= pc_ptr_d;
      lp_ptr_q <= lp_ptr_d;
      stcky_q  <= stcky_d;
    end
  end

  always_comb begin
    ps_redir      = 1'b0;
    ps_redir_addr = '0;
    if (lend_rpt) begin
      ps_redir      = 1'b1;
      ps_redir_addr = pc_top;
    end else if (rtrn_req && !pc_empty) begin
      ps_redir      = 1'b1;
      ps_redir_addr = pc_top;
    end
  end

  assign ps_pcstck      = pc_top;
  assign ps_pcstck_pntr = pc_ptr_q;
  assign ps_laddr       = lp_end_top;
  assign ps_curlcntr    = lp_cnt_top;
  assign ps_lp_pntr     = lp_ptr_q;
  assign ps_stcky       = {stcky_q, pc_full, pc_empty};
  assign ps_halt        = halt;

endmodule
